// File: rtl/class_demux_if.sv
// Chunk-in / vector-out bundle for the class-HV return path.
// slave modport is the reassembler's view, master is the driver/consumer view.
// Handshakes: a chunk transfers on a rising clk edge where chunk_valid and
// chunk_ready are both high; a vector transfers on an edge where hv_valid and
// hv_ready are both high. A source never waits for ready before raising valid.
// dbg_state mirrors the reassembler FSM state (0 IDLE, 1 COLLECT, 2 HOLD).
// hv_popcount exists only when CLASS_DEMUX_POPCOUNT_EN is defined.
interface class_demux_if #(
    parameter int HV_DIM      = 5000,
    parameter int DIMS_PER_CC = 500,
    parameter int CTR_W       = 4
);
    localparam int POP_W = $clog2(HV_DIM + 1);

    logic                   start;
    logic                   flush;
    logic                   chunk_valid;
    logic [DIMS_PER_CC-1:0] chunk_in;
    logic                   chunk_ready;
    logic [CTR_W-1:0]       nonbin_ctr;
    logic [HV_DIM-1:0]      class_hv;
    logic                   hv_valid;
    logic                   hv_ready;
    logic                   busy;
    logic [1:0]             dbg_state;
`ifdef CLASS_DEMUX_POPCOUNT_EN
    logic [POP_W-1:0]       hv_popcount;
`endif

    modport slave (
        input  start, flush, chunk_valid, chunk_in, hv_ready,
        output chunk_ready, nonbin_ctr, class_hv, hv_valid, busy, dbg_state
`ifdef CLASS_DEMUX_POPCOUNT_EN
        , output hv_popcount
`endif
    );

    modport master (
        output start, flush, chunk_valid, chunk_in, hv_ready,
        input  chunk_ready, nonbin_ctr, class_hv, hv_valid, busy, dbg_state
`ifdef CLASS_DEMUX_POPCOUNT_EN
        , input hv_popcount
`endif
    );
endinterface

// File: rtl/class_demux_out.sv
// class_demux_out: reassembles DIMS_PER_CC-wide class-HV chunks, one per
// accepted beat, into a full HV_DIM vector. Chunk k lands in
// class_hv[k*DIMS_PER_CC +: DIMS_PER_CC]; nonbin_ctr tells memory which
// chunk is expected next.
// Optional macro CLASS_DEMUX_POPCOUNT_EN adds hv_popcount, the running
// number of ones accumulated over the accepted chunks.
// HV_DIM must be an exact multiple of DIMS_PER_CC and 2**CTR_W must cover
// NUM_CHUNKS.
module class_demux_out #(
    parameter int HV_DIM      = 5000,
    parameter int DIMS_PER_CC = 500,
    parameter int CTR_W       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    class_demux_if.slave   bus
);
    localparam int NUM_CHUNKS = HV_DIM / DIMS_PER_CC;
    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic [HV_DIM-1:0] hv_q, hv_d;
    logic              accept;

    // Ready and valid are pure state decodes so they can never disagree with
    // the FSM, and they fall to 0 with the asynchronous reset.
    assign bus.chunk_ready = (state_q == COLLECT);
    assign bus.hv_valid    = (state_q == HOLD);
    assign bus.busy        = (state_q != IDLE);
    assign bus.nonbin_ctr  = ctr_q;
    assign bus.class_hv    = hv_q;
    assign bus.dbg_state   = state_q;

    // flush blocks the write even though chunk_ready is still high this cycle.
    assign accept = bus.chunk_valid & bus.chunk_ready & ~bus.flush;

    // State, chunk index and assembled vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            hv_q    <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            hv_q    <= hv_d;
        end
    end

    // Next-state logic: flush first, then the per-state transitions.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        hv_d    = hv_q;
        if (bus.flush) begin
            // class_hv is intentionally kept; only the control state resets.
            state_d = IDLE;
            ctr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = COLLECT;
                        ctr_d   = '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        hv_d[int'(ctr_q) * DIMS_PER_CC +: DIMS_PER_CC] = bus.chunk_in;
                        if (ctr_q == LAST_IDX) begin
                            state_d = HOLD;
                            ctr_d   = '0;
                        end else begin
                            ctr_d = ctr_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // A start coinciding with consumption chains straight into
                    // the next assembly with no idle cycle.
                    if (bus.hv_ready) begin
                        state_d = bus.start ? COLLECT : IDLE;
                        ctr_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ctr_d   = '0;
                end
            endcase
        end
    end

`ifdef CLASS_DEMUX_POPCOUNT_EN
    localparam int POP_W = $clog2(HV_DIM + 1);

    logic [POP_W-1:0] pop_q, pop_d;
    logic             start_acc;

    // A start is taken from IDLE, or from HOLD together with hv_ready.
    assign start_acc = bus.start & ((state_q == IDLE) |
                                    ((state_q == HOLD) & bus.hv_ready));
    assign bus.hv_popcount = pop_q;

    // Running ones count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end

    // Clear on flush or accepted start, otherwise add the accepted chunk.
    always_comb begin
        pop_d = pop_q;
        if (bus.flush || start_acc) begin
            pop_d = '0;
        end else if (accept) begin
            pop_d = pop_q + POP_W'($countones(bus.chunk_in));
        end
    end
`endif

endmodule

// File: tb/tb_class_demux_out.sv
// Directed testbench for class_demux_out: reset, back-to-back and gapped
// assembly, downstream backpressure, HOLD-to-COLLECT chaining, flush and
// asynchronous reset during collection.
module tb_class_demux_out;
  localparam int HV_DIM      = 5000;
  localparam int D           = 500;
  localparam int CTR_W       = 4;
  localparam int NUM_CHUNKS  = HV_DIM / D;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  logic [HV_DIM-1:0] exp_a;
  logic [HV_DIM-1:0] exp_c;
  logic [HV_DIM-1:0] exp_mix;

  class_demux_if #(.HV_DIM(HV_DIM), .DIMS_PER_CC(D), .CTR_W(CTR_W)) bus ();

  class_demux_out #(.HV_DIM(HV_DIM), .DIMS_PER_CC(D), .CTR_W(CTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pattern 0: chunk k is all k[0]; pattern 1: chunk k holds the value k
  function automatic logic [D-1:0] pat(input int sel, input int k);
    logic [31:0] kk;
    kk = k;
    if (sel == 0) return {D{kk[0]}};
    return D'(kk);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hv(input string tag, input logic [HV_DIM-1:0] obs, input logic [HV_DIM-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed_low=%h expected_low=%h differing_bits=%0d",
             tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.chunk_ready), 32'd0);
    chk({tag, "_hv_valid"}, 32'(bus.hv_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ctr"}, 32'(bus.nonbin_ctr), 32'd0);
    chk({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
  endtask

  task automatic chk_pop(input string tag, input int exp);
`ifdef CLASS_DEMUX_POPCOUNT_EN
    chk(tag, 32'(bus.hv_popcount), exp);
`endif
  endtask

  // driver: one start pulse accepted from IDLE
  task automatic do_start(input string tag);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, "_ready"}, 32'(bus.chunk_ready), 32'd1);
    chk({tag, "_ctr"}, 32'(bus.nonbin_ctr), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  // driver: chunks first..last of a pattern, gap idle cycles after each
  task automatic send_seq(input string tag, input int sel, input int first, input int last, input int gap);
    for (int k = first; k <= last; k++) begin
      bus.chunk_valid = 1'b1;
      bus.chunk_in    = pat(sel, k);
      step();
      bus.chunk_valid = 1'b0;
      bus.chunk_in    = '1;
      if (k < NUM_CHUNKS - 1) begin
        chk($sformatf("%s_ctr_k%0d", tag, k), 32'(bus.nonbin_ctr), k + 1);
        chk($sformatf("%s_nohv_k%0d", tag, k), 32'(bus.hv_valid), 32'd0);
        for (int g = 0; g < gap; g++) begin
          step();
          chk($sformatf("%s_gap_ctr_k%0d", tag, k), 32'(bus.nonbin_ctr), k + 1);
        end
      end else begin
        chk({tag, "_hv_valid"}, 32'(bus.hv_valid), 32'd1);
        chk({tag, "_ctr_wrap"}, 32'(bus.nonbin_ctr), 32'd0);
        chk({tag, "_ready_hold"}, 32'(bus.chunk_ready), 32'd0);
        chk({tag, "_state_hold"}, 32'(bus.dbg_state), 32'd2);
      end
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.flush       = 1'b0;
    bus.chunk_valid = 1'b0;
    bus.chunk_in    = '0;
    bus.hv_ready    = 1'b0;

    for (int k = 0; k < NUM_CHUNKS; k++) begin
      exp_a[k*D +: D] = pat(0, k);
      exp_c[k*D +: D] = pat(1, k);
      exp_mix[k*D +: D] = (k < 4) ? pat(1, k) : pat(0, k);
    end

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();

    // reset then idle
    chk_idle("reset");
    chk_hv("reset_hv", bus.class_hv, '0);
    chk_pop("reset_pop", 0);

    // back-to-back assembly of pattern 0
    do_start("b2b_start");
    send_seq("b2b", 0, 0, NUM_CHUNKS - 1, 0);
    chk_hv("b2b_hv", bus.class_hv, exp_a);
    chk_pop("b2b_pop", 2500);

    // backpressure in HOLD with a start pulse that must be ignored
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      step();
      bus.start = 1'b0;
      chk($sformatf("bp_hv_valid_%0d", i), 32'(bus.hv_valid), 32'd1);
      chk($sformatf("bp_ready_%0d", i), 32'(bus.chunk_ready), 32'd0);
      chk_hv($sformatf("bp_hv_%0d", i), bus.class_hv, exp_a);
    end
    chk_pop("bp_pop", 2500);
    bus.hv_ready = 1'b1;
    step();
    bus.hv_ready = 1'b0;
    chk_idle("bp_release");
    chk_hv("bp_release_hv_kept", bus.class_hv, exp_a);

    // gapped input: valid every 3rd cycle
    do_start("gap_start");
    chk_pop("gap_start_pop", 0);
    send_seq("gap", 0, 0, NUM_CHUNKS - 1, 2);
    chk_hv("gap_hv", bus.class_hv, exp_a);
    chk_pop("gap_pop", 2500);

    // hv_ready and start together in HOLD: straight into COLLECT
    bus.hv_ready = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.hv_ready = 1'b0;
    bus.start    = 1'b0;
    chk("chain_ready", 32'(bus.chunk_ready), 32'd1);
    chk("chain_hv_valid", 32'(bus.hv_valid), 32'd0);
    chk("chain_ctr", 32'(bus.nonbin_ctr), 32'd0);
    chk("chain_state", 32'(bus.dbg_state), 32'd1);
    chk_pop("chain_pop", 0);

    // four chunks of pattern 1, then flush with a competing valid chunk
    send_seq("pre_flush", 1, 0, 3, 0);
    bus.flush       = 1'b1;
    bus.chunk_valid = 1'b1;
    bus.chunk_in    = '1;
    step();
    bus.flush       = 1'b0;
    bus.chunk_valid = 1'b0;
    chk_idle("flush");
    chk_hv("flush_hv_kept", bus.class_hv, exp_mix);
    chk_pop("flush_pop", 0);
    step();
    chk("flush_stays_idle", 32'(bus.hv_valid), 32'd0);

    // full pattern 1 after flush, with an ignored start mid-collection
    do_start("post_flush_start");
    send_seq("post_flush_a", 1, 0, 4, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("collect_start_ignored_ctr", 32'(bus.nonbin_ctr), 32'd5);
    chk("collect_start_ignored_ready", 32'(bus.chunk_ready), 32'd1);
    send_seq("post_flush_b", 1, 5, NUM_CHUNKS - 1, 0);
    chk_hv("post_flush_hv", bus.class_hv, exp_c);
    chk_pop("post_flush_pop", 15);
    bus.hv_ready = 1'b1;
    step();
    bus.hv_ready = 1'b0;
    chk_idle("post_flush_release");

    // asynchronous reset after chunk 6
    do_start("rst_start");
    send_seq("pre_rst", 0, 0, 5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk_hv("async_rst_hv", bus.class_hv, '0);
    chk_pop("async_rst_pop", 0);
    step();
    rst_n = 1'b1;
    step();
    chk_idle("after_rst");
    chk_hv("after_rst_hv", bus.class_hv, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
